// File: rtl/clk_div_prog_multi.sv
// Multi-channel programmable integer clock divider with glitch-free ratio
// updates, per-channel tick strobes and a global phase-align strobe.
module clk_div_prog_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 4,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_clk_in,
    input  logic             i_rst_n,
    input  logic             i_sync,
    input  logic             i_cfg_we,
    input  logic [CH_W-1:0]  i_cfg_ch,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic [N_CH-1:0]  o_clk_out,
    output logic [N_CH-1:0]  o_tick,
    output logic [N_CH-1:0]  o_pending
);

    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    logic [DIV_W-1:0] r_s   [N_CH];
    logic [DIV_W-1:0] r_d   [N_CH];
    logic [DIV_W-1:0] r_cnt [N_CH];
    logic [N_CH-1:0]  r_clk;
    logic [N_CH-1:0]  r_tick;
    logic [N_CH-1:0]  r_pend;

    logic [DIV_W-1:0] w_sp  [N_CH];
    logic [DIV_W-1:0] w_cn  [N_CH];
    logic [DIV_W-1:0] w_h   [N_CH];
    logic [N_CH-1:0]  w_wr;
    logic [N_CH-1:0]  w_sp_en;
    logic [N_CH-1:0]  w_wrap;
    logic [N_CH-1:0]  w_dis;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_wr[c]    = i_cfg_we && (i_cfg_ch == CH_W'(c));
            w_sp[c]    = w_wr[c] ? i_cfg_div : r_s[c];
            w_sp_en[c] = w_sp[c] >= TWO;
            w_dis[c]   = r_d[c] < TWO;
            w_wrap[c]  = r_cnt[c] == (r_d[c] - ONE);
            w_cn[c]    = r_cnt[c] + ONE;
            w_h[c]     = r_d[c] - (r_d[c] >> 1);
        end
    end

    // Ratio is only adopted at a period boundary (wrap), while disabled,
    // or on SYNC, so a running period is never cut short or stretched.
    always_ff @(posedge i_clk_in or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_s[c]   <= DEF;
                r_d[c]   <= DEF;
                r_cnt[c] <= DEF - ONE;
            end
            r_clk  <= '0;
            r_tick <= '0;
            r_pend <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_s[c] <= w_sp[c];
                if (i_sync || w_dis[c]) begin
                    r_d[c]    <= w_sp[c];
                    r_cnt[c]  <= w_sp_en[c] ? (w_sp[c] - ONE) : '0;
                    r_clk[c]  <= 1'b0;
                    r_tick[c] <= 1'b0;
                    r_pend[c] <= 1'b0;
                end else if (w_wrap[c]) begin
                    r_d[c]    <= w_sp[c];
                    r_cnt[c]  <= '0;
                    r_clk[c]  <= w_sp_en[c];
                    r_tick[c] <= w_sp_en[c];
                    r_pend[c] <= 1'b0;
                end else begin
                    r_cnt[c]  <= w_cn[c];
                    r_clk[c]  <= w_cn[c] < w_h[c];
                    r_tick[c] <= 1'b0;
                    r_pend[c] <= r_pend[c] | w_wr[c];
                end
            end
        end
    end

    assign o_clk_out = r_clk;
    assign o_tick    = r_tick;
    assign o_pending = r_pend;

endmodule
